// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    ACC   = 2'd2,
    END   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  localparam int unsigned FAIR_LIMIT = 4;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant decision for the two SRAM requesters; port A has fixed priority.
// With SRAM_ARB_FAIR_EN defined, a starvation counter lets port B win after FAIR_LIMIT contested A grants.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_en,
  input  logic   a_req,
  input  logic   b_req,
  output logic   grant,
  output owner_e owner
);

  assign grant = arb_en & (a_req | b_req);

`ifdef SRAM_ARB_FAIR_EN
  logic [2:0] fair_cnt_q, fair_cnt_d;
  logic       b_turn;

  assign b_turn = (fair_cnt_q >= 3'(FAIR_LIMIT));

  always_comb begin
    owner      = (a_req && !(b_req && b_turn)) ? OWN_A : OWN_B;
    fair_cnt_d = fair_cnt_q;
    if (grant) begin
      if (owner == OWN_B) begin
        fair_cnt_d = 3'd0;
      end else if (b_req && (fair_cnt_q != 3'd7)) begin
        fair_cnt_d = fair_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_cnt_q <= 3'd0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end
`else
  logic unused_clk_rst;

  // Pure fixed priority: no state, so the clock and reset are not needed here.
  assign unused_clk_rst = clk ^ rst;
  assign owner          = a_req ? OWN_A : OWN_B;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port asynchronous SRAM arbiter: port A (display, read-only) and port B (host, read/write).
// Optional host fairness is enabled by defining SRAM_ARB_FAIR_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iA_REQ,
  input  logic [ADDR_W-1:0] iA_ADDR,
  output logic              oA_ACK,
  output logic [DATA_W-1:0] oA_RDATA,
  input  logic              iB_REQ,
  input  logic              iB_WE,
  input  logic [ADDR_W-1:0] iB_ADDR,
  input  logic [DATA_W-1:0] iB_WDATA,
  input  logic [1:0]        iB_BE,
  output logic              oB_ACK,
  output logic [DATA_W-1:0] oB_RDATA,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N
);
  // state | meaning
  // IDLE  | strobes inactive, address held, pending requests arbitrated
  // SETUP | address and CE presented; OE for reads, write data for writes
  // ACC   | OE or WE strobe for WAIT_CYC+1 cycles; read data captured on the last edge
  // END   | OE/WE released, CE held, write data still driven, requester ACKed

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d, grant_owner;
  logic                grant, grant_we;
  logic                we_q, we_d;
  logic [2:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  sram_arb_grant u_grant (
    .clk    (iCLK),
    .rst    (iRST),
    .arb_en (state_q == IDLE),
    .a_req  (iA_REQ),
    .b_req  (iB_REQ),
    .grant  (grant),
    .owner  (grant_owner)
  );

  assign grant_we = (grant_owner == OWN_B) && iB_WE;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    ub_n_d    = ub_n_q;
    lb_n_d    = lb_n_q;
    dq_oe_d   = dq_oe_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = SETUP;
          owner_d = grant_owner;
          we_d    = grant_we;
          addr_d  = (grant_owner == OWN_A) ? iA_ADDR : iB_ADDR;
          wdata_d = iB_WDATA;
          ce_n_d  = 1'b0;
          oe_n_d  = grant_we;
          dq_oe_d = grant_we;
          ub_n_d  = grant_we & ~iB_BE[1];
          lb_n_d  = grant_we & ~iB_BE[0];
          wait_d  = WAIT_INIT;
        end
      end
      SETUP: begin
        state_d = ACC;
        // A write with no byte lanes enabled keeps WE_N high for the whole access.
        we_n_d  = ~we_q | (ub_n_q & lb_n_q);
      end
      ACC: begin
        if (wait_q == 3'd0) begin
          state_d = END;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (owner_q == OWN_A) begin
            a_ack_d = 1'b1;
            if (!we_q) a_rdata_d = SRAM_DQ;
          end else begin
            b_ack_d = 1'b1;
            if (!we_q) b_rdata_d = SRAM_DQ;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      END: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      owner_q   <= OWN_A;
      we_q      <= 1'b0;
      wait_q    <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      we_q      <= we_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      dq_oe_q   <= dq_oe_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? wdata_q : 'z;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign oA_ACK    = a_ack_q;
  assign oB_ACK    = b_ack_q;
  assign oA_RDATA  = a_rdata_q;
  assign oB_RDATA  = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM device model plus a word-level reference memory and timing rules.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AW     = 18;
  localparam int DW     = 16;
  localparam int WC     = 1;
  localparam int LAT    = 3 + WC;
  localparam int PERIOD = 4 + WC;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b0;
  logic          iA_REQ = 1'b0, iB_REQ = 1'b0, iB_WE = 1'b0;
  logic [AW-1:0] iA_ADDR = '0, iB_ADDR = '0;
  logic [DW-1:0] iB_WDATA = '0;
  logic [1:0]    iB_BE = 2'b00;
  logic          oA_ACK, oB_ACK;
  logic [DW-1:0] oA_RDATA, oB_RDATA;
  wire  [DW-1:0] SRAM_DQ;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  logic [DW-1:0] dev_mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_a_rd = '0, exp_b_rd = '0;
  int            vectors = 0, errors = 0;
  logic          dev_drive;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iA_REQ(iA_REQ), .iA_ADDR(iA_ADDR), .oA_ACK(oA_ACK), .oA_RDATA(oA_RDATA),
    .iB_REQ(iB_REQ), .iB_WE(iB_WE), .iB_ADDR(iB_ADDR), .iB_WDATA(iB_WDATA), .iB_BE(iB_BE),
    .oB_ACK(oB_ACK), .oB_RDATA(oB_RDATA),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  always #5 iCLK = ~iCLK;

  // SRAM device: 16 words, indexed by the low address nibble.
  assign dev_drive = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ   = dev_drive ? dev_mem[SRAM_ADDR[3:0]] : 'z;
  always @(posedge iCLK) begin
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) dev_mem[SRAM_ADDR[3:0]][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) dev_mem[SRAM_ADDR[3:0]][7:0]  <= SRAM_DQ[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input logic [AW-1:0] addr);
    chk("idle_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
    chk("idle_dq_hiz", $countones(SRAM_DQ), 0);
    chk("idle_addr_held", SRAM_ADDR, addr);
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns in the following IDLE cycle.
  task automatic access(input bit port_b, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [1:0] be);
    int n, we_low, oe_low;
    logic ub_l, lb_l;
    bit acked, other;
    n = 0; we_low = 0; oe_low = 0; ub_l = 1'b1; lb_l = 1'b1; acked = 0; other = 0;
    if (port_b) begin
      iB_REQ = 1'b1; iB_WE = we; iB_ADDR = addr; iB_WDATA = data; iB_BE = be;
    end else begin
      iA_REQ = 1'b1; iA_ADDR = addr;
    end
    while (!acked && n < 20) begin
      @(posedge iCLK); #1;
      n++;
      if (!SRAM_WE_N) we_low++;
      if (!SRAM_OE_N) oe_low++;
      if (!SRAM_CE_N) begin
        ub_l = SRAM_UB_N; lb_l = SRAM_LB_N;
        if (we) chk("wr_dq_driven", SRAM_DQ, data);
      end
      if (!we && !dev_drive) chk("rd_dq_hiz", $countones(SRAM_DQ), 0);
      acked = port_b ? oB_ACK : oA_ACK;
      if (port_b ? oA_ACK : oB_ACK) other = 1;
    end
    if (we) begin
      if (be[1]) ref_mem[addr[3:0]][15:8] = data[15:8];
      if (be[0]) ref_mem[addr[3:0]][7:0]  = data[7:0];
    end else if (port_b) begin
      exp_b_rd = ref_mem[addr[3:0]];
    end else begin
      exp_a_rd = ref_mem[addr[3:0]];
    end
    chk("ack_seen", acked, 1);
    chk("ack_latency", n, LAT);
    chk("other_ack", other, 0);
    chk("sram_addr", SRAM_ADDR, addr);
    chk("we_low_cycles", we_low, (we && be != 2'b00) ? WC + 1 : 0);
    chk("oe_low_cycles", oe_low, we ? 0 : WC + 2);
    chk("byte_lanes", {ub_l, lb_l}, we ? {~be[1], ~be[0]} : 2'b00);
    chk("a_rdata", oA_RDATA, exp_a_rd);
    chk("b_rdata", oB_RDATA, exp_b_rd);
    iA_REQ = 1'b0; iB_REQ = 1'b0;
    @(posedge iCLK); #1;
    chk("ack_one_cycle", {oA_ACK, oB_ACK}, 2'b00);
    idle_checks(addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a_cnt;
    bit b_seen;
    logic [AW-1:0] ra;
    #2 iRST = 1'b1;
    #3;
    chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_dq_hiz", $countones(SRAM_DQ), 0);
    chk("rst_acks", {oA_ACK, oB_ACK}, 2'b00);
    chk("rst_rdata", {oA_RDATA, oB_RDATA}, 0);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK) iRST = 1'b0;
    @(posedge iCLK); #1;

    for (int i = 0; i < 16; i++)
      access(1'b1, 1'b1, {6'($urandom), 8'h00, 4'(i)}, 16'($urandom), 2'b11);

    // Full write then display readback.
    access(1'b1, 1'b1, 18'h00010, 16'hA5C3, 2'b11);
    access(1'b0, 1'b0, 18'h00010, 16'h0000, 2'b00);
    chk("readback_a5c3", oA_RDATA, 16'hA5C3);

    // Lower-byte-only write over 0xFFFF.
    access(1'b1, 1'b1, 18'h00020, 16'hFFFF, 2'b11);
    access(1'b1, 1'b1, 18'h00020, 16'h1234, 2'b01);
    access(1'b1, 1'b0, 18'h00020, 16'h0000, 2'b00);
    chk("readback_ff34", oB_RDATA, 16'hFF34);

    // Write with no byte lanes: full sequence, no WE pulse, memory unchanged.
    access(1'b1, 1'b1, 18'h00030, 16'h5555, 2'b00);
    access(1'b0, 1'b0, 18'h00030, 16'h0000, 2'b00);
    chk("be00_unchanged", oA_RDATA, 16'hFF34);

    // Simultaneous requests: A first, B one access period after A's ACK.
    iA_REQ = 1'b1; iA_ADDR = 18'h00003;
    iB_REQ = 1'b1; iB_WE = 1'b0; iB_ADDR = 18'h00004;
    n = 0; b_seen = 0;
    while (!oA_ACK && n < 20) begin
      @(posedge iCLK); #1; n++;
      if (oB_ACK) b_seen = 1;
    end
    iA_REQ = 1'b0;
    exp_a_rd = ref_mem[3];
    chk("contest_a_latency", n, LAT);
    chk("contest_b_not_first", b_seen, 0);
    chk("contest_a_rdata", oA_RDATA, exp_a_rd);
    n = 0;
    while (!oB_ACK && n < 20) begin
      @(posedge iCLK); #1; n++;
    end
    iB_REQ = 1'b0;
    exp_b_rd = ref_mem[4];
    chk("contest_b_after_a", n, PERIOD);
    chk("contest_b_rdata", oB_RDATA, exp_b_rd);
    @(posedge iCLK); #1;

    // A held continuously with B pending.
    iA_REQ = 1'b1; iA_ADDR = 18'h00007;
    iB_REQ = 1'b1; iB_WE = 1'b0; iB_ADDR = 18'h00009;
    a_cnt = 0; b_seen = 0;
    for (int c = 0; c < 8 * PERIOD && !b_seen; c++) begin
      @(posedge iCLK); #1;
      if (oA_ACK) a_cnt++;
      if (oB_ACK) b_seen = 1;
    end
    iA_REQ = 1'b0; iB_REQ = 1'b0;
    exp_a_rd = ref_mem[7];
`ifdef SRAM_ARB_FAIR_EN
    exp_b_rd = ref_mem[9];
    chk("fair_b_granted", b_seen, 1);
    chk("fair_a_grants", a_cnt, 4);
`else
    chk("fixed_b_starved", b_seen, 0);
    chk("fixed_a_grants", a_cnt, 8);
`endif
    chk("hold_a_rdata", oA_RDATA, exp_a_rd);
    chk("hold_b_rdata", oB_RDATA, exp_b_rd);
    @(posedge iCLK); #1;

    for (int i = 0; i < 24; i++) begin
      bit pb;
      pb = 1'($urandom_range(0, 1));
      ra = AW'($urandom);
      access(pb, pb ? 1'($urandom_range(0, 1)) : 1'b0, ra, 16'($urandom), 2'($urandom_range(0, 3)));
    end

    // Reset during the strobe window of a write.
    iB_REQ = 1'b1; iB_WE = 1'b1; iB_ADDR = 18'h0000F; iB_WDATA = 16'h3C3C; iB_BE = 2'b11;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    chk("acc_we_low", SRAM_WE_N, 0);
    iRST = 1'b1;
    #1;
    chk("abort_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
    chk("abort_dq_hiz", $countones(SRAM_DQ), 0);
    chk("abort_addr", SRAM_ADDR, 0);
    chk("abort_acks", {oA_ACK, oB_ACK}, 2'b00);
    chk("abort_rdata", {oA_RDATA, oB_RDATA}, 0);
    exp_a_rd = '0; exp_b_rd = '0;
    iB_REQ = 1'b0;
    @(posedge iCLK); #1;
    chk("abort_no_ack", {oA_ACK, oB_ACK}, 2'b00);
    @(negedge iCLK) iRST = 1'b0;
    @(posedge iCLK); #1;
    access(1'b1, 1'b0, 18'h00005, 16'h0000, 2'b00);
    access(1'b0, 1'b0, 18'h00006, 16'h0000, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
